// File: rtl/hs_req_tx.sv
// Transmit side of a 4-phase req/ack handshake carrying a W-bit word to an asynchronous receiver.
// Optional ack timeout enabled by defining HS_TIMEOUT_EN.
module hs_req_tx #(
    parameter int unsigned W              = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_send,
    input  logic [W-1:0] i_din,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_timeout,
    output logic         o_req_out,
    output logic [W-1:0] o_data_out,
    input  logic         i_ack_in
);

    typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

    state_e                 r_state, w_state_d;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   r_req, w_req_d;
    logic [W-1:0]           r_data, w_data_d;
    logic                   r_done, w_done_d;

`ifdef HS_TIMEOUT_EN
    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_timeout, w_timeout_d;
    // Set when REQ_LO was entered by timeout, so its exit produces no done pulse.
    logic            r_abort, w_abort_d;
`endif

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("hs_req_tx: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("hs_req_tx: TIMEOUT_CYCLES must be at least 1");
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack_in};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
`ifdef HS_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
`ifdef HS_TIMEOUT_EN
            r_cnt     <= w_cnt_d;
            r_timeout <= w_timeout_d;
            r_abort   <= w_abort_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
`ifdef HS_TIMEOUT_EN
        w_cnt_d     = r_cnt;
        w_timeout_d = 1'b0;
        w_abort_d   = r_abort;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_send && !o_busy) begin
                    w_data_d  = i_din;
                    w_req_d   = 1'b1;
                    w_state_d = StReqHi;
`ifdef HS_TIMEOUT_EN
                    w_cnt_d   = '0;
`endif
                end
            end
            StReqHi: begin
                if (w_ack_s) begin
                    w_req_d   = 1'b0;
                    w_state_d = StReqLo;
`ifdef HS_TIMEOUT_EN
                end else if (r_cnt == CntLast) begin
                    w_req_d     = 1'b0;
                    w_timeout_d = 1'b1;
                    w_abort_d   = 1'b1;
                    w_state_d   = StReqLo;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
`endif
                end
            end
            StReqLo: begin
                if (!w_ack_s) begin
                    w_state_d = StIdle;
`ifdef HS_TIMEOUT_EN
                    w_done_d  = !r_abort;
                    w_abort_d = 1'b0;
`else
                    w_done_d  = 1'b1;
`endif
                end
            end
            default: begin
                w_state_d = StIdle;
                w_req_d   = 1'b0;
            end
        endcase
    end

    // A late ack still high keeps the block busy so no new req overlaps it.
    assign o_busy     = (r_state != StIdle) | w_ack_s;
    assign o_done     = r_done;
    assign o_req_out  = r_req;
    assign o_data_out = r_data;
`ifdef HS_TIMEOUT_EN
    assign o_timeout  = r_timeout;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule
